// File: rtl/hex_display_scan.sv
// Multiplexed seven-segment scanner: DIGITS hex digits with per-digit dp/blank,
// PWM brightness and frame-synchronous double buffering of the displayed value.
module hex_display_scan #(
  parameter int DIGITS     = 8,
  parameter int DIV_LOG2   = 10,
  parameter int BRIGHT_W   = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  load_i,
  input  logic [BRIGHT_W-1:0]   brightness_i,
  output logic [DIGITS-1:0]     anodes_o,
  output logic [6:0]            segments_o,
  output logic                  dp_out_o,
  output logic                  frame_done_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_LOG2-1:0]  cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [4*DIGITS-1:0]  pend_data_q, disp_data_q;
  logic [DIGITS-1:0]    pend_dp_q, disp_dp_q;
  logic [DIGITS-1:0]    pend_blank_q, disp_blank_q;
  logic                 pend_valid_q;
  logic [DIGITS-1:0]    anodes_q;
  logic [6:0]           segments_q;
  logic                 dp_out_q;
  logic                 frame_done_q;

  logic                 slot_end;
  logic                 wrap;
  logic                 pwm_on;
  logic                 digit_on;
  logic [3:0]           nibble;
  logic [DIGITS-1:0]    anodes_d;
  logic [6:0]           segments_d;
  logic                 dp_out_d;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h7E;
      4'h1: font = 7'h30;
      4'h2: font = 7'h6D;
      4'h3: font = 7'h79;
      4'h4: font = 7'h33;
      4'h5: font = 7'h5B;
      4'h6: font = 7'h5F;
      4'h7: font = 7'h70;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h7B;
      4'hA: font = 7'h77;
      4'hB: font = 7'h1F;
      4'hC: font = 7'h4E;
      4'hD: font = 7'h3D;
      4'hE: font = 7'h4F;
      default: font = 7'h47;
    endcase
  endfunction

  assign slot_end = (cnt_q == {DIV_LOG2{1'b1}});
  assign wrap     = slot_end && (idx_q == IDX_LAST);
  // Top BRIGHT_W bits of the slot counter act as the PWM ramp.
  assign pwm_on   = (cnt_q[DIV_LOG2-1 -: BRIGHT_W] <= brightness_i);
  assign digit_on = pwm_on && !disp_blank_q[idx_q];
  assign nibble   = disp_data_q[idx_q*4 +: 4];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_anode
      assign anodes_d[gi] = ACTIVE_LOW ^ (digit_on && (idx_q == IDX_W'(gi)));
    end
  endgenerate

  assign segments_d = {7{ACTIVE_LOW}} ^ (digit_on ? font(nibble) : 7'h00);
  assign dp_out_d   = ACTIVE_LOW ^ (digit_on && disp_dp_q[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pend_valid_q <= 1'b0;
      anodes_q     <= {DIGITS{ACTIVE_LOW}};
      segments_q   <= {7{ACTIVE_LOW}};
      dp_out_q     <= ACTIVE_LOW;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + DIV_LOG2'(1);
      if (slot_end) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      // A load landing on the wrap edge bypasses the pending set entirely.
      if (load_i) begin
        pend_data_q  <= data_i;
        pend_dp_q    <= dp_i;
        pend_blank_q <= blank_i;
        if (wrap) begin
          disp_data_q  <= data_i;
          disp_dp_q    <= dp_i;
          disp_blank_q <= blank_i;
          pend_valid_q <= 1'b0;
        end else begin
          pend_valid_q <= 1'b1;
        end
      end else if (wrap && pend_valid_q) begin
        disp_data_q  <= pend_data_q;
        disp_dp_q    <= pend_dp_q;
        disp_blank_q <= pend_blank_q;
        pend_valid_q <= 1'b0;
      end
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      dp_out_q     <= dp_out_d;
      frame_done_q <= wrap;
    end
  end

  assign anodes_o     = anodes_q;
  assign segments_o   = segments_q;
  assign dp_out_o     = dp_out_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: a 4-digit active-high and a 6-digit active-low
// instance driven together and checked every cycle against a time-based model.
module tb_hex_display_scan;

  localparam int DL  = 4;
  localparam int DIV = 16;
  localparam int BW  = 2;
  localparam int NA  = 4;
  localparam int NB  = 6;
  localparam int FA  = NA * DIV;
  localparam int FB  = NB * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0;
  logic [1:0] bright = 2'd3;
  logic [63:0] in_data [2];
  logic [15:0] in_dp [2];
  logic [15:0] in_blank [2];

  logic [15:0] data_a;
  logic [3:0]  dp_a, blank_a, anodes_a;
  logic [6:0]  seg_a;
  logic        dpo_a, fd_a;
  logic [23:0] data_b;
  logic [5:0]  dp_b, blank_b, anodes_b;
  logic [6:0]  seg_b;
  logic        dpo_b, fd_b;

  assign data_a  = in_data[0][15:0];
  assign dp_a    = in_dp[0][3:0];
  assign blank_a = in_blank[0][3:0];
  assign data_b  = in_data[1][23:0];
  assign dp_b    = in_dp[1][5:0];
  assign blank_b = in_blank[1][5:0];

  always #5 clk = ~clk;

  hex_display_scan #(.DIGITS(NA), .DIV_LOG2(DL), .BRIGHT_W(BW), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_i(data_a), .dp_i(dp_a), .blank_i(blank_a),
    .load_i(load), .brightness_i(bright), .anodes_o(anodes_a), .segments_o(seg_a),
    .dp_out_o(dpo_a), .frame_done_o(fd_a));

  hex_display_scan #(.DIGITS(NB), .DIV_LOG2(DL), .BRIGHT_W(BW), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_i(data_b), .dp_i(dp_b), .blank_i(blank_b),
    .load_i(load), .brightness_i(bright), .anodes_o(anodes_b), .segments_o(seg_b),
    .dp_out_o(dpo_b), .frame_done_o(fd_b));

  // Model state: t = cycles into the current frame, D/P buffers, expected pins.
  int          t [2];
  logic [63:0] dd [2], pd [2];
  logic [15:0] ddp [2], pdp [2], dbl [2], pbl [2];
  bit          pv [2];
  logic [15:0] exp_an [2];
  logic [6:0]  exp_seg [2];
  logic        exp_dp [2], exp_fd [2];
  logic [6:0]  font_tab [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int flen(int k);  return (k == 0) ? FA : FB; endfunction
  function automatic int ndig(int k);  return (k == 0) ? NA : NB; endfunction
  function automatic logic [15:0] dmask(int k); return (16'(1) << ndig(k)) - 16'(1); endfunction

  function automatic logic [24:0] obs(int k);
    if (k == 0) return {fd_a, dpo_a, seg_a, 12'h000, anodes_a};
    return {fd_b, dpo_b, seg_b, 10'h000, anodes_b};
  endfunction

  function automatic logic [24:0] expv(int k);
    return {exp_fd[k], exp_dp[k], exp_seg[k], exp_an[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; dd[k] = '0; pd[k] = '0; ddp[k] = '0; pdp[k] = '0;
      dbl[k] = '0; pbl[k] = '0; pv[k] = 0; exp_fd[k] = 1'b0;
      exp_an[k]  = (k == 1) ? dmask(k) : 16'h0;
      exp_seg[k] = (k == 1) ? 7'h7F : 7'h00;
      exp_dp[k]  = (k == 1);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int idx, cnt;
      bit on, act, wrap;
      idx  = t[k] / DIV;
      cnt  = t[k] % DIV;
      on   = ((cnt * (2 ** BW)) / DIV) <= int'(bright);
      act  = on && !dbl[k][idx];
      wrap = (t[k] == flen(k) - 1);
      exp_an[k]  = act ? (16'(1) << idx) : 16'h0;
      exp_seg[k] = act ? font_tab[dd[k][idx*4 +: 4]] : 7'h00;
      exp_dp[k]  = act && ddp[k][idx];
      if (k == 1) begin
        exp_an[k]  = ~exp_an[k] & dmask(k);
        exp_seg[k] = ~exp_seg[k];
        exp_dp[k]  = ~exp_dp[k];
      end
      exp_fd[k] = wrap;
      if (load) begin
        if (wrap) begin
          dd[k] = in_data[k]; ddp[k] = in_dp[k]; dbl[k] = in_blank[k]; pv[k] = 0;
        end else begin
          pd[k] = in_data[k]; pdp[k] = in_dp[k]; pbl[k] = in_blank[k]; pv[k] = 1;
        end
      end else if (wrap && pv[k]) begin
        dd[k] = pd[k]; ddp[k] = pdp[k]; dbl[k] = pbl[k]; pv[k] = 0;
      end
      t[k] = (t[k] + 1) % flen(k);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [63:0] d, input logic [15:0] p, input logic [15:0] b);
    in_data[0] = d; in_data[1] = d; in_dp[0] = p; in_dp[1] = p;
    in_blank[0] = b; in_blank[1] = b; load = 1'b1;
    $display("load data=%h dp=%h blank=%h t_a=%0d t_b=%0d", d[23:0], p[5:0], b[5:0], t[0], t[1]);
    step();
    load = 1'b0;
  endtask

  task automatic run_cmp(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", tag, k, i, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; bright = 2'd3;
    for (int k = 0; k < 2; k++) begin in_data[k] = '0; in_dp[k] = '0; in_blank[k] = '0; end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) step();
    do_load(64'h0000_0000_00BE_EF12, 16'h0, 16'h0);
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({anodes_a, seg_a, dpo_a, fd_a} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_async_a got=%h want=0", {anodes_a, seg_a, dpo_a, fd_a});
    end
    n_cmp++;
    if ({anodes_b, seg_b, dpo_b, fd_b} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async_b got=%h want=%h", {anodes_b, seg_b, dpo_b, fd_b},
               {6'h3F, 7'h7F, 1'b1, 1'b0});
    end
    model_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (obs(k) !== expv(k)) begin
        n_bad++;
        $display("FAIL reset_hold inst=%0d got=%h want=%h", k, obs(k), expv(k));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_scan();
    int fa, fb;
    run_cmp(FB + 10, "scan_after_reset");
    do_load(64'h0000_0000_0054_3210, 16'h0, 16'h0);
    fa = 0; fb = 0;
    for (int i = 0; i < 2 * FB; i++) begin
      step();
      fa += int'(fd_a); fb += int'(fd_b);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== expv(k)) begin
          n_bad++;
          $display("FAIL basic_scan inst=%0d cyc=%0d got=%h want=%h", k, i, obs(k), expv(k));
        end
      end
    end
    n_cmp++;
    if (fa != 3 || fb != 2) begin
      n_bad++;
      $display("FAIL frame_count got=%0d/%0d want=3/2", fa, fb);
    end
  endtask

  task automatic test_tear_free();
    for (int i = 0; i < FA && (t[0] / DIV) != 2; i++) step();
    n_cmp++;
    if ((t[0] / DIV) != 2) begin
      n_bad++;
      $display("FAIL tear_wait got_slot=%0d want=2", t[0] / DIV);
    end
    do_load(64'h0000_0000_009A_BCD0 | 64'hABCD, 16'h0, 16'h0);
    run_cmp(2 * FA, "tear_free");
  endtask

  task automatic test_load_at_wrap();
    for (int i = 0; i < FA && t[0] != FA - 1; i++) step();
    n_cmp++;
    if (t[0] != FA - 1) begin
      n_bad++;
      $display("FAIL wrap_wait got=%0d want=%0d", t[0], FA - 1);
    end
    do_load(64'h0000_0000_00FF_FFFF, 16'h0, 16'h0);
    step();
    n_cmp++;
    if (seg_a !== 7'h47 || anodes_a !== 4'b0001) begin
      n_bad++;
      $display("FAIL wrap_load_digit0 got=%h/%b want=47/0001", seg_a, anodes_a);
    end
    run_cmp(FA, "after_wrap_load");
  endtask

  task automatic test_pwm();
    for (int b = 1; b >= 0; b--) begin
      int on_cnt;
      bright = 2'(b);
      on_cnt = 0;
      for (int i = 0; i < 2 * FA; i++) begin
        step();
        on_cnt += int'(anodes_a != 4'h0);
        for (int k = 0; k < 2; k++) begin
          n_cmp++;
          if (obs(k) !== expv(k)) begin
            n_bad++;
            $display("FAIL pwm_b%0d inst=%0d cyc=%0d got=%h want=%h", b, k, i, obs(k), expv(k));
          end
        end
      end
      n_cmp++;
      if (on_cnt != (b + 1) * 32) begin
        n_bad++;
        $display("FAIL pwm_duty_b%0d got=%0d want=%0d", b, on_cnt, (b + 1) * 32);
      end
    end
    bright = 2'd3;
  endtask

  task automatic test_blank_dp_polarity();
    int dark, dp_hits;
    do_load(64'h0000_0000_0076_5432, 16'h0001, 16'h0004);
    run_cmp(FB + 2, "blank_dp_load");
    dark = 0; dp_hits = 0;
    for (int i = 0; i < FB; i++) begin
      step();
      dark    += int'(anodes_b == 6'h3F && seg_b == 7'h7F);
      dp_hits += int'(anodes_b == 6'h3E && dpo_b == 1'b0);
    end
    n_cmp++;
    if (dark != DIV || dp_hits != DIV) begin
      n_bad++;
      $display("FAIL blank_dp_counts got=%0d/%0d want=%0d/%0d", dark, dp_hits, DIV, DIV);
    end
  endtask

  task automatic test_nonpow2();
    int last, bad_period, bad_onehot, pulses;
    logic [5:0] act;
    last = -1; bad_period = 0; bad_onehot = 0; pulses = 0;
    for (int i = 0; i < 3 * FB + 5; i++) begin
      step();
      act = ~anodes_b;
      if ($countones(act) > 1) bad_onehot++;
      if (fd_b) begin
        if (last >= 0 && i - last != FB) bad_period++;
        last = i; pulses++;
      end
    end
    n_cmp++;
    if (bad_period != 0 || pulses != 3 || bad_onehot != 0) begin
      n_bad++;
      $display("FAIL nonpow2 bad_period=%0d pulses=%0d bad_onehot=%0d want=0/3/0",
               bad_period, pulses, bad_onehot);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++)
      do_load({$urandom, $urandom}, 16'($urandom), 16'($urandom) & 16'h0012);
    run_cmp(2 * FB, "back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) bright = 2'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_load({$urandom, $urandom}, 16'($urandom), 16'($urandom) & 16'($urandom));
      run_cmp($urandom_range(1, 40), "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    font_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    @(negedge clk);
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_load_at_wrap();
    test_pwm();
    test_blank_dp_polarity();
    test_nonpow2();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
